// File: rtl/sci_tx_seq_pkg.sv
// Shared types and constants for the SCI transmit sequencer.
// No logic; register map of the SCI channel and FSM state encoding.
// Imported by the sequencer top and its byte FIFO.
package sci_tx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POLL = 3'd1,
    WAIT = 3'd2,
    WTDR = 3'd3,
    WSSR = 3'd4
  } SCI_SEQ_STATE_t;

  // Channel 0 register block; channel N sits at SCI_BASE | N<<3.
  localparam logic [27:0] SCI_BASE     = 28'h5FFFEC0;
  localparam logic [27:0] SCI_TDR_OFS  = 28'h3;
  localparam logic [27:0] SCI_SSR_OFS  = 28'h4;

  // SSR sits in the top byte lane, TDR in the bottom one.
  localparam logic [3:0]  SCI_BA_SSR   = 4'b1000;
  localparam logic [3:0]  SCI_BA_TDR   = 4'b0001;

  // TDRE is SSR bit 7, i.e. bit 31 of the bus word.
  localparam int          SSR_TDRE_BIT = 31;

  // Written to SSR after loading TDR: TDRE=0, other flags kept, MPBT=0.
  localparam logic [7:0]  SSR_TDRE_CLR = 8'h7E;

  function automatic logic [27:0] sci_base(input int ch);
    return SCI_BASE | (28'(ch) << 3);
  endfunction

endpackage

// File: rtl/sci_tx_seq_if.sv
// Internal bus between the sequencer (master) and the SCI register block.
// A transfer completes on a clock-enabled edge with IBUS_REQ=1, IBUS_BUSY=0.
// Slave stalls by holding IBUS_BUSY; master holds A/DO/BA/WE until completion.
interface sci_tx_seq_if;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;

  modport master (
    output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DI, IBUS_BUSY
  );

  modport slave (
    input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DI, IBUS_BUSY
  );
endinterface

// File: rtl/sci_tx_seq_fifo.sv
// Byte FIFO feeding the SCI transmit sequencer (pointers, LEVEL, storage).
// Push visible one clock-enabled edge later; head is combinational from rptr.
// Push while full is dropped; flush wins over push and pop in the same cycle.
module sci_seq_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ce,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);
  import sci_tx_seq_pkg::*;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rptr];

  // Storage write; a flushed push never lands.
  always_ff @(posedge CLK) begin
    if (ce && push_ok && !flush) begin
      mem[wptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (ce) begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop_ok)  rptr <= rptr + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

endmodule

// File: rtl/sci_tx_seq.sv
// SCI transmit sequencer: drains a byte FIFO into the SCI TDR via polled SSR.
// Each byte costs POLL + TDR write + SSR write, one CE_R edge each if unstalled.
// IBUS_BUSY stalls any transfer; define SCI_SEQ_TXI_WAIT_EN to back off on TXI.
module sci_tx_seq #(
  parameter int N          = 0,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CE_R,
  input  logic                EN,
  input  logic                FLUSH,
  input  logic                OVF_CLR,
  input  logic [7:0]          WR_DATA,
  input  logic                WR_REQ,
  output logic                FULL,
  output logic                EMPTY,
  output logic [DEPTH_LOG2:0] LEVEL,
  output logic                OVF,
  output logic                ACTIVE,
  input  logic                TXI,
  sci_tx_seq_if.master        ibus
);
  import sci_tx_seq_pkg::*;

  localparam logic [27:0] BASE = sci_base(N);

  SCI_SEQ_STATE_t state;
  SCI_SEQ_STATE_t state_nxt;

  logic        xfer_done;
  logic        pop;
  logic        flush_req;
  logic        flush_now;
  logic        flush_pend;
  logic        wait_done;
  logic [7:0]  head;
  logic        req_d;
  logic        we_d;
  logic [27:0] a_d;
  logic [31:0] do_d;
  logic [3:0]  ba_d;

  assign xfer_done = req_d & ~ibus.IBUS_BUSY;
  assign pop       = (state == WTDR) & xfer_done;

  // A flush seen while TDR is being written must not move the head under
  // the outstanding write, so it is parked and applied with that pop.
  assign flush_req = FLUSH | flush_pend;
  assign flush_now = flush_req & ((state != WTDR) | xfer_done);

  sci_seq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ce    (CE_R),
    .push  (WR_REQ),
    .din   (WR_DATA),
    .pop   (pop),
    .flush (flush_now),
    .head  (head),
    .level (LEVEL),
    .full  (FULL),
    .empty (EMPTY)
  );

`ifdef SCI_SEQ_TXI_WAIT_EN
  assign wait_done = TXI;

  logic unused_ok;
  assign unused_ok = ^ibus.IBUS_DI[SSR_TDRE_BIT-1:0];
`else
  logic [3:0] bo_cnt;

  // Backoff timer: runs only in WAIT, so each WAIT lasts 16 CE_R cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bo_cnt <= '0;
    end else if (CE_R) begin
      bo_cnt <= (state == WAIT) ? bo_cnt + 1'b1 : 4'd0;
    end
  end

  assign wait_done = (bo_cnt == 4'hF);

  logic unused_ok;
  assign unused_ok = ^{ibus.IBUS_DI[SSR_TDRE_BIT-1:0], TXI};
`endif

  // Sticky overflow: a push into a full FIFO sets it; set beats clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (CE_R) begin
      OVF <= (WR_REQ & FULL) | (OVF & ~OVF_CLR);
    end
  end

  // Deferred flush holder, live only while a TDR write is outstanding.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flush_pend <= 1'b0;
    end else if (CE_R) begin
      flush_pend <= (state == WTDR) & ~xfer_done & flush_req;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else if (CE_R) begin
      state <= state_nxt;
    end
  end

  // Next state and bus drive; outputs decode from state so they hold while stalled.
  always_comb begin
    state_nxt = state;
    req_d     = 1'b0;
    we_d      = 1'b0;
    a_d       = '0;
    do_d      = '0;
    ba_d      = '0;
    case (state)
      IDLE: begin
        if (EN && !EMPTY) state_nxt = POLL;
      end
      POLL: begin
        req_d = 1'b1;
        a_d   = BASE + SCI_SSR_OFS;
        ba_d  = SCI_BA_SSR;
        if (xfer_done) begin
          if (!EN || EMPTY)                     state_nxt = IDLE;
          else if (ibus.IBUS_DI[SSR_TDRE_BIT])  state_nxt = WTDR;
          else                                  state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!EN || EMPTY)  state_nxt = IDLE;
        else if (wait_done) state_nxt = POLL;
      end
      WTDR: begin
        req_d = 1'b1;
        we_d  = 1'b1;
        a_d   = BASE + SCI_TDR_OFS;
        ba_d  = SCI_BA_TDR;
        do_d  = {24'h0, head};
        if (xfer_done) state_nxt = WSSR;
      end
      WSSR: begin
        req_d = 1'b1;
        we_d  = 1'b1;
        a_d   = BASE + SCI_SSR_OFS;
        ba_d  = SCI_BA_SSR;
        do_d  = {SSR_TDRE_CLR, 24'h0};
        if (xfer_done) state_nxt = (EN && !EMPTY) ? POLL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ACTIVE        = (state != IDLE);
  assign ibus.IBUS_REQ = req_d;
  assign ibus.IBUS_WE  = we_d;
  assign ibus.IBUS_A   = a_d;
  assign ibus.IBUS_DO  = do_d;
  assign ibus.IBUS_BA  = ba_d;

endmodule

// File: tb/tb_sci_tx_seq.sv
// Directed bench for sci_tx_seq on channel 1 with an 8-byte FIFO.
// A bus monitor logs every completed transfer with its cycle number.
// The SSR model returns TDRE from a bench variable; BUSY is bench-driven.
module tb_sci_tx_seq;
  import sci_tx_seq_pkg::*;

  localparam logic [27:0] A_SSR = 28'h5FFFECC;
  localparam logic [27:0] A_TDR = 28'h5FFFECB;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE_R = 1'b1;
  logic       EN = 1'b0;
  logic       FLUSH = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       WR_REQ = 1'b0;
  logic       TXI = 1'b0;
  logic       FULL, EMPTY, OVF, ACTIVE;
  logic [3:0] LEVEL;
  logic       tdre = 1'b0;
  logic       busy = 1'b0;

  sci_tx_seq_if ibus ();
  assign ibus.IBUS_DI   = {tdre, 31'h0};
  assign ibus.IBUS_BUSY = busy;

  sci_tx_seq #(.N(1), .DEPTH_LOG2(3)) dut (
    .CLK (CLK), .RST_N (RST_N), .CE_R (CE_R), .EN (EN), .FLUSH (FLUSH),
    .OVF_CLR (OVF_CLR), .WR_DATA (WR_DATA), .WR_REQ (WR_REQ), .FULL (FULL),
    .EMPTY (EMPTY), .LEVEL (LEVEL), .OVF (OVF), .ACTIVE (ACTIVE), .TXI (TXI),
    .ibus (ibus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [27:0] a;
    logic [31:0] d;
    logic [3:0]  ba;
    logic        we;
    int          t;
  } txn_t;

  int   cyc = 0;
  txn_t txq[$];
  int   checks = 0;
  int   failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (RST_N && CE_R && ibus.IBUS_REQ && !ibus.IBUS_BUSY)
      txq.push_back('{ibus.IBUS_A, ibus.IBUS_DO, ibus.IBUS_BA, ibus.IBUS_WE, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    WR_DATA = b;
    WR_REQ  = 1'b1;
    step();
    WR_REQ  = 1'b0;
  endtask

  task automatic wait_txn(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("txn_count", 32'(txq.size()), 32'(n));
  endtask

  task automatic wait_bus(input logic we, input logic [3:0] ba, input string tag);
    int k = 0;
    logic found = 1'b0;
    while (!found && k < 20) begin
      if (ibus.IBUS_REQ && ibus.IBUS_WE == we && ibus.IBUS_BA == ba) found = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step();
    chk("rst_empty",  32'(EMPTY), 32'd1);
    chk("rst_full",   32'(FULL), 32'd0);
    chk("rst_level",  32'(LEVEL), 32'd0);
    chk("rst_ovf",    32'(OVF), 32'd0);
    chk("rst_active", 32'(ACTIVE), 32'd0);
    chk("rst_req",    32'(ibus.IBUS_REQ), 32'd0);
    chk("rst_we",     32'(ibus.IBUS_WE), 32'd0);
    chk("rst_a",      32'(ibus.IBUS_A), 32'd0);
    chk("rst_do",     ibus.IBUS_DO, 32'd0);
    chk("rst_ba",     32'(ibus.IBUS_BA), 32'd0);
    RST_N = 1'b1;
    step();

    // Single byte, TDRE already set: poll, TDR write, SSR write
    push(8'h55);
    chk("one_level", 32'(LEVEL), 32'd1);
    tdre = 1'b1;
    EN   = 1'b1;
    wait_txn(3, 30);
    chk("one_poll_a",  32'(txq[0].a), 32'(A_SSR));
    chk("one_poll_ba", 32'({txq[0].we, txq[0].ba}), 32'h08);
    chk("one_tdr_a",   32'(txq[1].a), 32'(A_TDR));
    chk("one_tdr_ba",  32'({txq[1].we, txq[1].ba}), 32'h11);
    chk("one_tdr_do",  txq[1].d, 32'h00000055);
    chk("one_ssr_a",   32'(txq[2].a), 32'(A_SSR));
    chk("one_ssr_ba",  32'({txq[2].we, txq[2].ba}), 32'h18);
    chk("one_ssr_do",  txq[2].d, 32'h7E000000);
    chk("one_active",  32'(ACTIVE), 32'd0);
    chk("one_empty",   32'(EMPTY), 32'd1);
    EN = 1'b0;
    txq.delete();

    // Fill to full across the pointer wrap, then overflow
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("full_flag",  32'(FULL), 32'd1);
    chk("full_level", 32'(LEVEL), 32'd8);
    chk("full_ovf0",  32'(OVF), 32'd0);
    push(8'hEE);
    chk("ovf_set",    32'(OVF), 32'd1);
    chk("ovf_level",  32'(LEVEL), 32'd8);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    chk("ovf_clr",    32'(OVF), 32'd0);
    EN = 1'b1;
    wait_txn(24, 120);
    for (int i = 0; i < 8; i++) chk("drain_tdr", txq[3*i+1].d, 32'h10 + 32'(i));
    repeat (5) step();
    chk("drain_total", 32'(txq.size()), 32'd24);
    chk("drain_level", 32'(LEVEL), 32'd0);
    EN = 1'b0;
    txq.delete();

`ifdef SCI_SEQ_TXI_WAIT_EN
    // TDRE clear: no re-poll until TXI
    tdre = 1'b0;
    push(8'hA5);
    EN = 1'b1;
    wait_txn(1, 20);
    repeat (30) step();
    chk("txi_no_repoll", 32'(txq.size()), 32'd1);
    TXI = 1'b1;
    step();
    TXI = 1'b0;
    chk("txi_poll", 32'({ibus.IBUS_REQ, ibus.IBUS_WE}), 32'h2);
    tdre = 1'b1;
    wait_txn(4, 20);
    chk("txi_tdr_do", txq[2].d, 32'h000000A5);
`else
    // TDRE clear: re-poll on the 16-cycle backoff, stretched by CE_R gaps
    tdre = 1'b0;
    push(8'hA5);
    EN = 1'b1;
    wait_txn(3, 80);
    chk("bo_gap01", 32'(txq[1].t - txq[0].t), 32'd17);
    chk("bo_gap12", 32'(txq[2].t - txq[1].t), 32'd17);
    chk("bo_poll_rd", 32'({txq[2].we, txq[2].ba}), 32'h08);
    CE_R = 1'b0;
    repeat (5) step();
    CE_R = 1'b1;
    tdre = 1'b1;
    wait_txn(6, 60);
    chk("bo_gap23_ce", 32'(txq[3].t - txq[2].t), 32'd22);
    chk("bo_tdr_a",   32'(txq[4].a), 32'(A_TDR));
    chk("bo_tdr_do",  txq[4].d, 32'h000000A5);
`endif
    chk("bo_idle", 32'(ACTIVE), 32'd0);
    EN = 1'b0;
    txq.delete();

    // Stalled TDR write with a flush pulse: flush waits for the pop
    tdre = 1'b1;
    push(8'h31);
    push(8'h32);
    EN = 1'b1;
    wait_bus(1'b1, 4'b0001, "stall_wtdr");
    busy  = 1'b1;
    FLUSH = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      FLUSH = 1'b0;
      chk("stall_a",   32'(ibus.IBUS_A), 32'(A_TDR));
      chk("stall_do",  ibus.IBUS_DO, 32'h00000031);
      chk("stall_lvl", 32'(LEVEL), 32'd2);
    end
    busy = 1'b0;
    step();
    chk("stall_flushed", 32'(LEVEL), 32'd0);
    chk("stall_wssr", 32'({ibus.IBUS_REQ, ibus.IBUS_WE, ibus.IBUS_BA}), 32'h38);
    step();
    chk("stall_idle", 32'(ACTIVE), 32'd0);
    chk("stall_tdr_do", txq[1].d, 32'h00000031);
    chk("stall_ssr_do", txq[2].d, 32'h7E000000);
    EN = 1'b0;
    txq.delete();

    // Reset mid-WSSR, then three clean sequences
    push(8'h60);
    EN = 1'b1;
    wait_bus(1'b1, 4'b1000, "rst_in_wssr");
    RST_N = 1'b0;
    #1;
    chk("arst_req",    32'(ibus.IBUS_REQ), 32'd0);
    chk("arst_we",     32'(ibus.IBUS_WE), 32'd0);
    chk("arst_a",      32'(ibus.IBUS_A), 32'd0);
    chk("arst_do",     ibus.IBUS_DO, 32'd0);
    chk("arst_ba",     32'(ibus.IBUS_BA), 32'd0);
    chk("arst_active", 32'(ACTIVE), 32'd0);
    chk("arst_empty",  32'(EMPTY), 32'd1);
    EN = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    step();
    txq.delete();
    push(8'h61);
    push(8'h62);
    push(8'h63);
    EN = 1'b1;
    wait_txn(9, 60);
    chk("seq_tdr0", txq[1].d, 32'h00000061);
    chk("seq_tdr1", txq[4].d, 32'h00000062);
    chk("seq_tdr2", txq[7].d, 32'h00000063);
    chk("seq_poll2", 32'({txq[6].we, txq[6].ba}), 32'h08);
    chk("seq_ssr2", txq[8].d, 32'h7E000000);
    chk("seq_idle", 32'(ACTIVE), 32'd0);
    chk("seq_empty", 32'(EMPTY), 32'd1);
    EN = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
